// File: rtl/mult_pkg.sv
// Shared definitions for the 2-bit multiplier path: product width/range,
// handshake state encoding and a constant clog2 helper.
package mult_pkg;

    localparam int PROD_W   = 4;
    localparam int MAX_PROD = 9;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums up to COUNT multiplier products per block (early close on in_last) and
// presents the block sum/count on a registered valid/ready output.
module product_accumulator #(
    parameter int  PROD_W   = mult_pkg::PROD_W,
    parameter int  COUNT    = 4,
    parameter int  MAX_PROD = mult_pkg::MAX_PROD,
    localparam int ACC_W    = PROD_W + mult_pkg::clog2(COUNT),
    localparam int CNT_W    = mult_pkg::clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              err
);
    import mult_pkg::*;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next, sum_next, prod_ext;
    logic [CNT_W-1:0] cnt, cnt_next, count_inc;
    logic [ACC_W-1:0] out_sum_next;
    logic [CNT_W-1:0] out_count_next;
    logic             out_valid_next, err_next;
    logic             accept, closing;

    // Ready depends only on state and downstream ready, never on in_valid.
    assign in_ready = !rst && ((state == ACCUM) || out_ready);
    assign accept   = in_valid && in_ready;
    assign prod_ext = ACC_W'(in_prod);

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        cnt_next       = cnt;
        out_valid_next = out_valid;
        out_sum_next   = out_sum;
        out_count_next = out_count;
        err_next       = err || (accept && (in_prod > PROD_W'(MAX_PROD)));
        sum_next       = acc + prod_ext;
        count_inc      = cnt + 1'b1;
        closing        = (count_inc == CNT_W'(COUNT)) || in_last;

        unique case (state)
            ACCUM: begin
                if (accept) begin
                    if (closing) begin
                        out_sum_next   = sum_next;
                        out_count_next = count_inc;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        cnt_next       = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next = sum_next;
                        cnt_next = count_inc;
                    end
                end
            end
            HOLD: begin
                // A beat accepted while the sum drains opens the next block.
                if (out_ready) begin
                    if (accept && ((COUNT == 1) || in_last)) begin
                        out_sum_next   = prod_ext;
                        out_count_next = CNT_W'(1);
                        acc_next       = '0;
                        cnt_next       = '0;
                    end else if (accept) begin
                        acc_next       = prod_ext;
                        cnt_next       = CNT_W'(1);
                        out_valid_next = 1'b0;
                        state_next     = ACCUM;
                    end else begin
                        out_valid_next = 1'b0;
                        state_next     = ACCUM;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_valid <= out_valid_next;
            out_sum   <= out_sum_next;
            out_count <= out_count_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus a
// randomized run against a queue-based block model.
module tb_product_accumulator;

    localparam int PROD_W = 4;
    localparam int COUNT  = 4;
    localparam int ACC_W  = 6;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, in_last, out_valid, out_ready, err;
    logic [PROD_W-1:0] in_prod;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;

    int errors = 0;
    int checks = 0;

    // Model: products of the open block, plus the last emitted block result.
    int m_blk[$];
    bit m_pending = 1'b0;
    bit m_err     = 1'b0;
    bit m_ready   = 1'b0;
    int m_sum     = 0;
    int m_count   = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(PROD_W), .COUNT(COUNT), .MAX_PROD(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .err(err)
    );

    task automatic drive(input logic r, input logic v, input logic [PROD_W-1:0] p,
                         input logic l, input logic o);
        rst = r; in_valid = v; in_prod = p; in_last = l; out_ready = o;
        m_ready = !r && (!m_pending || o);
        #1;
    endtask

    task automatic clock_edge();
        int s;
        @(posedge clk);
        if (rst) begin
            m_pending = 1'b0; m_err = 1'b0; m_sum = 0; m_count = 0;
            m_blk.delete();
        end else begin
            if (m_pending && out_ready) m_pending = 1'b0;
            if (in_valid && m_ready) begin
                m_blk.push_back(int'(in_prod));
                if (in_prod > 9) m_err = 1'b1;
                if (m_blk.size() == COUNT || in_last) begin
                    s = 0;
                    foreach (m_blk[k]) s += m_blk[k];
                    m_sum = s; m_count = m_blk.size(); m_pending = 1'b1;
                    m_blk.delete();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 4'd5, 0, 1);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
            clock_edge();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== 6'd0) begin errors++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
        checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        drive(0, 0, 4'd0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_block();
        int prods[4] = '{1, 4, 6, 9};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, PROD_W'(prods[i]), 0, 1);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready beat %0d: got %b expected 1", i, in_ready); end
            clock_edge();
            checks++; if (out_valid !== (i == 3)) begin errors++; $display("FAIL full_latency beat %0d: got %b expected %b", i, out_valid, i == 3); end
        end
        checks++; if (out_sum !== 6'd20 || m_sum != 20) begin errors++; $display("FAIL full_sum: got %0d expected 20 (model %0d)", out_sum, m_sum); end
        checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", out_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", err); end
        drive(0, 0, 4'd0, 0, 1);
        clock_edge();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_max_values();
        for (int i = 0; i < 4; i++) begin drive(0, 1, 4'd9, 0, 1); clock_edge(); end
        checks++; if (out_sum !== 6'b100100) begin errors++; $display("FAIL max_sum: got %0d expected 36", out_sum); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err: got %b expected 0", err); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4'd15, 0, 1); clock_edge();
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err beat %0d: got %b expected 1", i, err); end
        end
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'd60) begin errors++; $display("FAIL illegal_sum: got valid=%b sum=%0d expected valid=1 sum=60", out_valid, out_sum); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 4'd0, 0, 1); clock_edge();
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky cycle %0d: got %b expected 1", i, err); end
        end
        drive(1, 0, 4'd0, 0, 1); clock_edge();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        drive(0, 0, 4'd0, 0, 1);
    endtask

    task automatic test_early_close();
        drive(0, 1, 4'd3, 0, 1); clock_edge();
        drive(0, 1, 4'd2, 1, 1); clock_edge();
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'd5 || out_count !== 3'd2) begin errors++; $display("FAIL early_close: got valid=%b sum=%0d count=%0d expected 1/5/2", out_valid, out_sum, out_count); end
        drive(0, 0, 4'd0, 1, 1); clock_edge();
        for (int i = 0; i < 4; i++) begin drive(0, 1, 4'd1, 0, 1); clock_edge(); end
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 3'd4) begin errors++; $display("FAIL after_early: got valid=%b sum=%0d count=%0d expected 1/4/4", out_valid, out_sum, out_count); end
        drive(0, 0, 4'd0, 0, 1); clock_edge();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin drive(0, 1, 4'd1, 0, 1); clock_edge(); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'd7, 0, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
            clock_edge();
            checks++; if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 3'd4) begin errors++; $display("FAIL bp_hold cycle %0d: got valid=%b sum=%0d count=%0d expected 1/4/4", i, out_valid, out_sum, out_count); end
        end
        drive(0, 0, 4'd0, 0, 1); clock_edge();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 4'd2, 0, 1);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat %0d: got %b expected 1", i, in_ready); end
            clock_edge();
            if ((i % 4) == 3) begin
                checks++; if (out_valid !== 1'b1 || out_sum !== 6'd8 || out_count !== 3'd4) begin errors++; $display("FAIL b2b_sum beat %0d: got valid=%b sum=%0d count=%0d expected 1/8/4", i, out_valid, out_sum, out_count); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap beat %0d: got %b expected 0", i, out_valid); end
            end
        end
        for (int i = 0; i < 4; i++) begin drive(0, 1, 4'd1, i == 3, 1); clock_edge(); end
        checks++; if (out_valid !== 1'b1 || out_count !== 3'd4 || out_sum !== 6'd4) begin errors++; $display("FAIL last_on_count: got valid=%b sum=%0d count=%0d expected 1/4/4", out_valid, out_sum, out_count); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 4'd0, 1, 1); clock_edge();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_empty_block cycle %0d: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 2; i++) begin drive(0, 1, 4'd3, 0, 1); clock_edge(); end
        drive(1, 0, 4'd0, 0, 1); clock_edge();
        checks++; if (out_valid !== 1'b0 || out_sum !== 6'd0) begin errors++; $display("FAIL mid_reset: got valid=%b sum=%0d expected 0/0", out_valid, out_sum); end
        for (int i = 0; i < 4; i++) begin drive(0, 1, 4'd1, 0, 1); clock_edge(); end
        checks++; if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 3'd4) begin errors++; $display("FAIL mid_reset_next: got valid=%b sum=%0d count=%0d expected 1/4/4", out_valid, out_sum, out_count); end
    endtask

    task automatic test_random();
        logic r, v, l, o;
        logic [PROD_W-1:0] p;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 7) == 0) ? PROD_W'($urandom_range(10, 15)) : PROD_W'($urandom_range(0, 9));
            l = ($urandom_range(0, 5) == 0);
            o = ($urandom_range(0, 3) != 0);
            drive(r, v, p, l, o);
            checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rand_in_ready cycle %0d: got %b expected %b", i, in_ready, m_ready); end
            clock_edge();
            checks++; if (out_valid !== m_pending) begin errors++; $display("FAIL rand_valid cycle %0d: got %b expected %b", i, out_valid, m_pending); end
            checks++; if (out_sum !== ACC_W'(m_sum) || out_count !== CNT_W'(m_count)) begin errors++; $display("FAIL rand_result cycle %0d: got sum=%0d count=%0d expected sum=%0d count=%0d", i, out_sum, out_count, m_sum, m_count); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err cycle %0d: got %b expected %b", i, err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_max_values();
        test_early_close();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 2-bit multiplier stage.
- Accepts 4-bit products over a valid/ready handshake and sums COUNT products, or fewer if in_last arrives first.
- Presents the block sum and beat count on a registered valid/ready output.
- Flags products the 2x2 multiplier can never produce (above 9) as a sticky error.

Parameters:
- PROD_W, 4: product width; matches the {P3,P2,P1,P0} multiplier output.
- COUNT, 4: maximum products per block; legal range 1..16.
- MAX_PROD, 9: largest legal product; larger values set err.
- ACC_W, derived localparam: PROD_W + clog2(COUNT), 6 at defaults. Always holds (2^PROD_W - 1) * COUNT without overflow.
- CNT_W, derived localparam: clog2(COUNT + 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream product valid
- in_ready  output  1  block accepts a product this cycle
- in_prod  input  PROD_W  product from the multiplier
- in_last  input  1  this beat closes the block early
- out_valid  output  1  block sum available
- out_ready  input  1  downstream accepts the sum
- out_sum  output  ACC_W  accumulated sum
- out_count  output  CNT_W  number of products in the block (1..COUNT)
- err  output  1  sticky: some in_prod exceeded MAX_PROD

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=ACCUM; acc=0; cnt=0; out_valid=0; out_sum=0; out_count=0; err=0.
- in_ready is forced to 0 while rst is high.
- Accept rule: a beat is accepted when in_valid && in_ready.
- in_ready = (state==ACCUM) || out_ready. This is combinational from state and out_ready only, never from in_valid.
- State ACCUM, on accept:
  - acc <= acc + in_prod, zero-extended to ACC_W; cnt <= cnt + 1.
  - If cnt+1 == COUNT or in_last == 1: out_sum <= acc + in_prod, out_count <= cnt + 1, out_valid <= 1, acc <= 0, cnt <= 0, state <= HOLD.
- State HOLD: out_sum and out_count are held stable while out_valid && !out_ready.
- HOLD, out_ready=1 with no accept: out_valid <= 0; state <= ACCUM.
- HOLD, out_ready=1 with accept (back-to-back):
  - The beat is the first of the next block: acc <= in_prod, cnt <= 1.
  - If COUNT==1 or in_last: stay in HOLD, reload out_sum=in_prod, out_count=1, out_valid stays 1. Otherwise go to ACCUM.
- Latency: the closing beat is accepted at edge t; out_valid is high from edge t to edge t+1.
- Throughput: one product per cycle sustained while out_ready is held high.
- in_last on the COUNT-th beat: same behaviour as without in_last; no empty block is emitted.
- in_last is ignored when in_valid=0.
- Illegal product: in_prod > MAX_PROD on an accepted beat sets err=1. The value is still accumulated. err clears only on rst.
- Reset mid-block: partial acc/cnt are discarded and no output is emitted. Reset while out_valid=1 drops the pending sum.
- in_prod and in_last are sampled only on accepted beats.

Decomposition:
- Shared package mult_pkg:
  - PROD_W and MAX_PROD constants.
  - State enum {ACCUM, HOLD}.
  - clog2 function, reused by later multiplier-path stages.
- No sub-module is needed. The datapath is one adder plus a counter. The handshake stays inline.

Test Plan:
- Full block: after reset, products 1,4,6,9 on consecutive cycles with out_ready=1 -> out_valid one cycle later, out_sum=20, out_count=4, err=0.
- Max values: 9,9,9,9 -> out_sum=36 (6'b100100). Then illegal 15,15,15,15 -> out_sum=60, err=1 and stays 1 until rst.
- Early close: 3 then 2 with in_last=1 -> out_sum=5, out_count=2. A following 4-beat block of 1s -> out_sum=4, which proves acc cleared.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_sum and out_count stable, in_ready=0. Raising out_ready drops out_valid next cycle.
- Back-to-back: out_valid=1, out_ready=1, in_valid=1, in_prod=2 in the same cycle -> sum accepted, next block starts with acc=2, cnt=1. Sustained stream of 2s -> one sum of 8 every 4 cycles, no bubbles.
- Reset mid-block: 2 beats accepted, then rst for one cycle -> out_valid=0, out_sum=0. The next 4 beats of 1 -> out_sum=4, out_count=4.
